// File: rtl/bus_arb_if.sv
// Transaction bus between a master and a slave.
// req_pkt = {we, addr, wdata, strb}; rsp_pkt = {ok, rdata}.
interface bus_trans_if #(
    parameter int BTI_AW = 32,
    parameter int BTI_DW = 32
);
    localparam int RQW = 1 + BTI_AW + BTI_DW + BTI_DW / 8;
    localparam int RSW = 1 + BTI_DW;

    logic           req_vld;
    logic           req_rdy;
    logic [RQW-1:0] req_pkt;
    logic           rsp_vld;
    logic           rsp_rdy;
    logic [RSW-1:0] rsp_pkt;

    modport master (
        output req_vld, req_pkt, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_pkt
    );

    modport slave (
        input  req_vld, req_pkt, rsp_rdy,
        output req_rdy, rsp_vld, rsp_pkt
    );
endinterface

// File: rtl/bus_arb.sv
// Round-robin arbiter sharing one slave among NM masters,
// with in-order response routing through an ID FIFO.
module bus_arb #(
    parameter int NM        = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int OST_DEPTH = 2,
    localparam int IW = (NM > 1) ? $clog2(NM) : 1,
    localparam int CW = $clog2(OST_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_trans_if.slave    m_if [NM],
    bus_trans_if.master   s_if,
    output logic [CW-1:0] ost_cnt
);
    localparam int RQW = 1 + AW + DW + DW / 8;
    localparam int PW  = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;

    logic [NM-1:0]  req_vld_a;
    logic [NM-1:0]  rsp_rdy_a;
    logic [RQW-1:0] req_pkt_a [NM];

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] hold_id_q, hold_id_d;
    logic          hold_vld_q, hold_vld_d;
    logic [IW-1:0] fifo_q [OST_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          win_vld;
    logic [IW-1:0] win_id;
    logic [IW:0]   scan_sum;
    logic [IW-1:0] scan_idx;
    logic [IW-1:0] head;
    logic          full, empty, push, pop;
    logic          s_req_vld, s_rsp_rdy;

    for (genvar i = 0; i < NM; i++) begin : g_m
        assign req_vld_a[i]    = m_if[i].req_vld;
        assign req_pkt_a[i]    = m_if[i].req_pkt;
        assign rsp_rdy_a[i]    = m_if[i].rsp_rdy;
        assign m_if[i].req_rdy = push & (win_id == IW'(i));
        assign m_if[i].rsp_vld = rst_n & s_if.rsp_vld & ~empty
                               & (head == IW'(i));
        assign m_if[i].rsp_pkt = s_if.rsp_pkt;
    end

    // A locked grant wins outright; otherwise scan from rr_ptr.
    always_comb begin
        win_vld  = hold_vld_q;
        win_id   = hold_id_q;
        scan_sum = '0;
        scan_idx = '0;
        if (!hold_vld_q) begin
            for (int k = 0; k < NM; k++) begin
                scan_sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
                if (scan_sum >= (IW+1)'(NM))
                    scan_sum = scan_sum - (IW+1)'(NM);
                scan_idx = scan_sum[IW-1:0];
                if (!win_vld && req_vld_a[scan_idx]) begin
                    win_vld = 1'b1;
                    win_id  = scan_idx;
                end
            end
        end
    end

    assign full      = (cnt_q == CW'(OST_DEPTH));
    assign empty     = (cnt_q == '0);
    assign s_req_vld = rst_n & win_vld & ~full;
    assign push      = s_req_vld & s_if.req_rdy;
    assign head      = fifo_q[rd_ptr_q];
    assign s_rsp_rdy = rst_n & ~empty & rsp_rdy_a[head];
    assign pop       = s_if.rsp_vld & s_rsp_rdy;

    assign s_if.req_vld = s_req_vld;
    assign s_if.req_pkt = (rst_n & win_vld) ? req_pkt_a[win_id] : '0;
    assign s_if.rsp_rdy = s_rsp_rdy;
    assign ost_cnt      = cnt_q;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        hold_vld_d = hold_vld_q;
        hold_id_d  = hold_id_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        if (push) begin
            rr_ptr_d   = (win_id == IW'(NM - 1)) ? '0 : win_id + 1'b1;
            hold_vld_d = 1'b0;
            wr_ptr_d   = (wr_ptr_q == PW'(OST_DEPTH - 1)) ? '0
                                                          : wr_ptr_q + 1'b1;
        end else if (s_req_vld) begin
            hold_vld_d = 1'b1;
            hold_id_d  = win_id;
        end
        if (pop)
            rd_ptr_d = (rd_ptr_q == PW'(OST_DEPTH - 1)) ? '0
                                                        : rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            hold_vld_q <= 1'b0;
            hold_id_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            hold_vld_q <= hold_vld_d;
            hold_id_q  <= hold_id_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // ID storage needs no reset; validity is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= win_id;
    end
endmodule

// File: doc/bus_arb.md
Name: bus_arb

Overview:
- Round-robin arbiter that shares one downstream bus_trans_if slave (memory, peripheral fabric) among NM upstream masters, e.g. instruction fetch and load/store.
- Request channel: combinational pass-through from the granted master.
- Response routing: in-order, via an ID FIFO of issued grants, so up to OST_DEPTH transactions can be outstanding on the slave.
- The downstream slave must return responses in request order.

Parameters:
- NM, 2, number of upstream masters (>=2); ID width IW = $clog2(NM).
- AW, 32, bus address width (BTI_AW of all interfaces).
- DW, 32, bus data width (BTI_DW of all interfaces).
- OST_DEPTH, 2, max outstanding (accepted, not yet responded) transactions; power of two, >=1.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst_n  input  1  synchronous active-low reset.
- m_if[NM]  bus_trans_if.slave  AW/DW  upstream master ports; index = master ID, 0 = lowest.
- s_if  bus_trans_if.master  AW/DW  downstream shared slave port.
- ost_cnt  output  $clog2(OST_DEPTH)+1  current outstanding count, for debug/perf.

Behaviour:
- Reset, with rst_n low sampled at posedge:
  - rr_ptr=0, ID FIFO empty, ost_cnt=0, hold_vld=0.
  - While rst_n is low, force all outputs inactive: s_if.req_vld=0, s_if.rsp_rdy=0, every m_if.req_rdy=0, every m_if.rsp_vld=0.
- Arbitration (combinational):
  - If hold_vld, winner=hold_id.
  - Otherwise winner = first i scanning rr_ptr, rr_ptr+1, ... mod NM with m_if[i].req_vld=1.
  - No requester means no winner.
- Request path:
  - full = (ost_cnt==OST_DEPTH).
  - s_if.req_vld = winner exists & !full.
  - s_if.req_pkt = m_if[winner].req_pkt (zero when no winner).
  - m_if[i].req_rdy = (i==winner) & s_if.req_rdy & !full.
  - Zero cycles of added latency; no request registering.
- Grant lock:
  - If s_if.req_vld & !s_if.req_rdy, set hold_vld=1 and hold_id=winner for the next cycle.
  - This keeps the presented packet stable until accepted and prevents a valid request from being withdrawn by re-arbitration.
  - Clear hold_vld on req handshake.
  - Masters must not drop req_vld before req_rdy.
- On request handshake (s_if.req_vld & s_if.req_rdy):
  - Push winner ID into the FIFO.
  - rr_ptr <= (winner+1) mod NM. Wrap from NM-1 to 0.
  - rr_ptr does not change on cycles without a handshake.
- Response path:
  - head = FIFO head ID.
  - m_if[head].rsp_vld = s_if.rsp_vld & !empty; all other rsp_vld=0.
  - rsp_pkt is broadcast to all masters unchanged.
  - s_if.rsp_rdy = !empty & m_if[head].rsp_rdy.
  - On response handshake, pop.
- Full/empty:
  - Full blocks new request handshakes, even when a pop occurs the same cycle (no bypass).
  - Empty forces s_if.rsp_rdy=0; a spurious s_if.rsp_vld is ignored and stalls the slave.
- Simultaneous push and pop (not full): ost_cnt unchanged, FIFO pointers both advance.
- Same-cycle completion: a request whose response arrives the same cycle it is accepted is not routed; the response is seen from the next cycle.
- Reset mid-transaction: all outstanding state is discarded. The downstream slave must be reset together with the arbiter.
- Counters: pointers wrap modulo OST_DEPTH; ost_cnt ranges 0..OST_DEPTH.

Test Plan:
- Single master: m0 write addr=0x100 data=0xDEADBEEF strobe=0xF, slave req_rdy=1, response 2 cycles later ok=1.
  - Required: s_if sees m0 packet same cycle.
  - m0.rsp_vld=1, ok=1; m1.rsp_vld never asserted; ost_cnt 0->1->0.
- Contention: m0 and m1 both hold req_vld continuously, slave always ready, responses 1 cycle later.
  - Required: grants alternate m0, m1, m0, m1 from reset.
  - Each response goes to the matching master in issue order.
- Backpressure lock: m1 requests with rr_ptr=1, s_if.req_rdy=0 for 3 cycles, m0 raises req_vld in cycle 2.
  - Required: s_if.req_pkt stays m1's for all 4 cycles.
  - m1 is accepted in cycle 4; m0 is granted next.
- Outstanding limit, OST_DEPTH=2: three back-to-back requests, slave delays responses.
  - Required: the first two are accepted; the third sees req_rdy=0 until the first response pops; ost_cnt peaks at 2.
- Response backpressure: head master m1 holds rsp_rdy=0 for 2 cycles with s_if.rsp_vld=1.
  - Required: s_if.rsp_rdy=0 for those cycles; the FIFO does not pop; m0.rsp_vld stays 0.
- Reset mid-flight: assert rst_n=0 with ost_cnt=2, release.
  - Required: ost_cnt=0, rr_ptr=0, all rsp_vld/req_rdy=0 during reset.
  - The first post-reset request from m1 is granted normally.
